// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: runs one ADC conversion over a byte SPI master.
// Sends a command byte and a dummy byte, returns the 12-bit result.
//
// Ports:
//   clk, reset        clock, async active-low reset
//   start, cont_en    single-shot request / continuous mode enable
//   ch_sel            channel for the next conversion
//   spi_done,
//   spi_received      SPI master done flag and received byte
//   spi_transmit,
//   spi_to_send       SPI master transmit request and byte to send
//   cs_n              ADC chip-select, active low
//   sample,
//   sample_ch,
//   sample_valid      result, its channel, one-cycle strobe
//   busy, timeout_err not idle / sticky abort flag
module adc_spi_sequencer #(
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int CONV_PERIOD  = 1000,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cont_en,
  input  logic [2:0]  ch_sel,
  input  logic        spi_done,
  input  logic [7:0]  spi_received,
  output logic        spi_transmit,
  output logic [7:0]  spi_to_send,
  output logic        cs_n,
  output logic [11:0] sample,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CMAX = (CS_SETUP_CYC > CS_HOLD_CYC) ?
                        CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(CONV_PERIOD);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    LOAD,
    XFER,
    RELEASE,
    CS_HOLD,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] per_cnt;
  logic [WW-1:0] wdog;
  logic          idx;
  logic [2:0]    ch_q;
  logic [3:0]    rx0_lo;
  logic [7:0]    rx1;
  logic          trig;
  logic          wdog_exp;

  assign trig = (state == IDLE) &&
                (start || (cont_en && per_cnt == '0));
  assign wdog_exp = (wdog == WW'(TIMEOUT_CYC - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      per_cnt      <= '0;
      wdog         <= '0;
      idx          <= 1'b0;
      ch_q         <= '0;
      rx0_lo       <= '0;
      rx1          <= '0;
      spi_transmit <= 1'b0;
      spi_to_send  <= '0;
      cs_n         <= 1'b1;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;

      // Start-to-start period; a late conversion leaves it at 0,
      // so the next trigger fires on the first idle cycle.
      if (!cont_en)
        per_cnt <= '0;
      else if (trig)
        per_cnt <= PW'(CONV_PERIOD - 1);
      else if (per_cnt != '0)
        per_cnt <= per_cnt - 1'b1;

      unique case (state)
        IDLE: begin
          if (trig) begin
            ch_q        <= ch_sel;
            timeout_err <= 1'b0;
            cnt         <= '0;
            idx         <= 1'b0;
            cs_n        <= 1'b0;
            state       <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (cnt == CW'(CS_SETUP_CYC - 1)) begin
            spi_to_send <= {1'b1, ch_q, 4'b0000};
            state       <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD: begin
          spi_transmit <= 1'b1;
          wdog         <= '0;
          state        <= XFER;
        end
        XFER: begin
          if (spi_done) begin
            if (idx) rx1 <= spi_received;
            else     rx0_lo <= spi_received[3:0];
            spi_transmit <= 1'b0;
            wdog         <= '0;
            state        <= RELEASE;
          end else if (wdog_exp) begin
            spi_transmit <= 1'b0;
            cs_n         <= 1'b1;
            timeout_err  <= 1'b1;
            state        <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RELEASE: begin
          // Wait for the master to drop done before the next byte.
          if (!spi_done) begin
            if (!idx) begin
              idx         <= 1'b1;
              spi_to_send <= 8'h00;
              state       <= LOAD;
            end else begin
              cnt   <= '0;
              state <= CS_HOLD;
            end
          end else if (wdog_exp) begin
            cs_n        <= 1'b1;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        CS_HOLD: begin
          if (cnt == CW'(CS_HOLD_CYC - 1)) begin
            cs_n         <= 1'b1;
            sample       <= {rx0_lo, rx1};
            sample_ch    <= ch_q;
            sample_valid <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          spi_transmit <= 1'b0;
          cs_n         <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb_adc_spi_sequencer: directed bench for adc_spi_sequencer.
// Includes a byte-level SPI master model and handshake monitor.
module tb_adc_spi_sequencer;

  localparam int BYTE_CYC = 4;
  localparam int PERIOD   = 100;
  localparam int LAT      = 2 + 2 + 2 * (1 + BYTE_CYC + 1) + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cont_en;
  logic [2:0]  ch_sel;
  logic        spi_done;
  logic [7:0]  spi_received;
  logic        spi_transmit;
  logic [7:0]  spi_to_send;
  logic        cs_n;
  logic [11:0] sample;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic        busy;
  logic        timeout_err;

  adc_spi_sequencer #(
    .CS_SETUP_CYC(2),
    .CS_HOLD_CYC (2),
    .CONV_PERIOD (PERIOD),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cont_en     (cont_en),
    .ch_sel      (ch_sel),
    .spi_done    (spi_done),
    .spi_received(spi_received),
    .spi_transmit(spi_transmit),
    .spi_to_send (spi_to_send),
    .cs_n        (cs_n),
    .sample      (sample),
    .sample_ch   (sample_ch),
    .sample_valid(sample_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit         model_en;
  bit         echo;
  logic [7:0] resp0;
  logic [7:0] resp1;
  int         mcnt;
  bit         mbyte;
  logic [2:0] mch;
  logic       prev_tx;
  logic       prev_done;
  logic [7:0] prev_tos;
  logic [7:0] tx_byte;
  int         tx_rises;
  logic [7:0] tx_log [2];

  // Monitor first (sees pre-update done), then the SPI model.
  always @(negedge clk) begin
    if (!reset) begin
      spi_done     = 1'b0;
      spi_received = 8'h00;
      mcnt         = 0;
      mbyte        = 1'b0;
      tx_rises     = 0;
      prev_tx      = 1'b0;
      prev_done    = 1'b0;
      prev_tos     = 8'h00;
    end else begin
      if (spi_transmit && !prev_tx) begin
        chk("tx_preload", spi_to_send, prev_tos);
        tx_byte = spi_to_send;
        if (tx_rises < 2) tx_log[tx_rises] = spi_to_send;
        tx_rises++;
      end
      if (spi_transmit)
        chk("tx_stable", spi_to_send, tx_byte);
      if (prev_tx && prev_done)
        chk("tx_drop", spi_transmit, 0);
      if (spi_to_send != prev_tos)
        chk("load_wait", prev_done, 0);
      if (sample_valid) begin
        chk("tx_pulses", tx_rises, 2);
        tx_rises = 0;
      end else if (!busy) begin
        tx_rises = 0;
      end

      if (model_en && spi_transmit && !spi_done) begin
        mcnt++;
        if (mcnt == BYTE_CYC) begin
          mcnt     = 0;
          spi_done = 1'b1;
          if (!mbyte) begin
            mch          = spi_to_send[6:4];
            spi_received = resp0;
          end else begin
            spi_received = echo ? {5'b0, mch} : resp1;
          end
          mbyte = !mbyte;
        end
      end else if (!spi_transmit && spi_done) begin
        spi_done = 1'b0;
      end

      prev_tx   = spi_transmit;
      prev_done = spi_done;
      prev_tos  = spi_to_send;
    end
  end

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start(input logic [2:0] ch);
    ch_sel = ch;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_cs_n"}, cs_n, 1);
    chk({pfx, "_tx"}, spi_transmit, 0);
    chk({pfx, "_to_send"}, spi_to_send, 0);
    chk({pfx, "_sample"}, sample, 0);
    chk({pfx, "_sample_ch"}, sample_ch, 0);
    chk({pfx, "_valid"}, sample_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_terr"}, timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit ok;
    int lat;
    int n;
    int nv;
    int t [5];
    int expch;

    reset    = 1'b0;
    start    = 1'b0;
    cont_en  = 1'b0;
    ch_sel   = 3'd0;
    model_en = 1'b1;
    echo     = 1'b0;
    resp0    = 8'hA5;
    resp1    = 8'h3C;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single shot, channel 5
    pulse_start(3'd5);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
      chk("ss_busy", busy, 1);
      chk("ss_cs_n", cs_n, 0);
      @(negedge clk);
      lat++;
    end
    chk("ss_done", ok, 1);
    chk("ss_latency", lat, LAT);
    chk("ss_cs_done", cs_n, 1);
    chk("ss_sample", sample, 12'h53C);
    chk("ss_ch", sample_ch, 5);
    chk("ss_byte0", tx_log[0], 8'hD0);
    chk("ss_byte1", tx_log[1], 8'h00);
    @(negedge clk);
    chk("ss_valid_1cyc", sample_valid, 0);
    chk("ss_idle", busy, 0);

    // Continuous mode, result echoes the channel
    echo    = 1'b1;
    resp0   = 8'h00;
    expch   = 1;
    ch_sel  = 3'(expch);
    cont_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(150, ok);
      chk("cont_valid", ok, 1);
      t[i] = cyc;
      chk("cont_ch", sample_ch, expch);
      chk("cont_echo", sample, expch);
      expch  = expch + 1;
      ch_sel = 3'(expch);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++)
      chk("cont_period", t[i+1] - t[i], PERIOD);
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("cont_next_start", ok, 1);
    repeat (3) @(negedge clk);
    cont_en = 1'b0;
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      if (sample_valid) nv++;
      @(negedge clk);
    end
    chk("cont_tail", nv, 1);

    // Start during XFER is ignored; ch_sel change does not leak
    echo  = 1'b0;
    resp0 = 8'h12;
    resp1 = 8'h34;
    pulse_start(3'd2);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (spi_transmit) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ign_xfer", ok, 1);
    pulse_start(3'd7);
    wait_valid(60, ok);
    chk("ign_valid", ok, 1);
    chk("ign_ch", sample_ch, 2);
    chk("ign_sample", sample, 12'h234);
    @(negedge clk);
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      if (sample_valid) nv++;
      @(negedge clk);
    end
    chk("ign_no_extra", nv, 0);
    chk("ign_idle", busy, 0);

    // Timeout: spi_done never comes
    model_en = 1'b0;
    pulse_start(3'd1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (spi_transmit) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("tmo_xfer", ok, 1);
    n  = 0;
    nv = 0;
    for (int i = 0; i < 400; i++) begin
      if (!spi_transmit) break;
      if (sample_valid) nv++;
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 255);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_cs_n", cs_n, 1);
    chk("tmo_tx", spi_transmit, 0);
    chk("tmo_idle", busy, 0);
    chk("tmo_sample", sample, 12'h234);
    for (int i = 0; i < 5; i++) begin
      if (sample_valid) nv++;
      @(negedge clk);
    end
    chk("tmo_no_valid", nv, 0);
    chk("tmo_sticky", timeout_err, 1);

    model_en = 1'b1;
    resp0    = 8'h0F;
    resp1    = 8'hF0;
    pulse_start(3'd3);
    chk("tmo_clear", timeout_err, 0);
    wait_valid(60, ok);
    chk("tmo_recover", ok, 1);
    chk("tmo_rec_sample", sample, 12'hFF0);
    chk("tmo_rec_ch", sample_ch, 3);
    @(negedge clk);

    // Async reset during the second byte
    resp0 = 8'h11;
    resp1 = 8'h22;
    pulse_start(3'd6);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (spi_transmit && spi_to_send == 8'h00) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ar_byte1", ok, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("ar");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    resp0 = 8'hA5;
    resp1 = 8'h3C;
    pulse_start(3'd4);
    wait_valid(60, ok);
    chk("ar_recover", ok, 1);
    chk("ar_sample", sample, 12'h53C);
    chk("ar_ch", sample_ch, 4);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
